// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED mode sequencer.
package led_seq_pkg;

    localparam int MODE_WIDTH = 3;

    typedef enum logic [MODE_WIDTH-1:0] {
        ST_PASS   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_ROTATE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_BLINK  = 3'd4
    } state_t;

    // Circular left shift by one: bit7 wraps into bit0.
    function automatic logic [7:0] rotl1(input logic [7:0] value);
        return {value[6:0], value[7]};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYCLES clocks;
// clear restarts the period so the next tick lands TICK_CYCLES cycles later.
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int          TICK_WIDTH  = 32
) (
    input  logic clk,
    input  logic rstb,
    input  logic clear,
    output logic tick
);

    logic [TICK_WIDTH-1:0] count_r;
    logic                  at_end_s;

    assign at_end_s = (count_r == TICK_WIDTH'(TICK_CYCLES - 1));
    assign tick     = at_end_s;

    // Period counter with synchronous reset, restart on clear and wrap at end.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            count_r <= {TICK_WIDTH{1'b0}};
        end else if (clear || at_end_s) begin
            count_r <= {TICK_WIDTH{1'b0}};
        end else begin
            count_r <= count_r + {{(TICK_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED mode sequencer: PASS, HOLD, ROTATE, COUNT and optional BLINK.
// Define LED_SEQ_BLINK_EN to compile in the BLINK state.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int          TICK_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [7:0]            switch,
    input  logic                  button_center_db,
    output logic [7:0]            led,
    output logic [MODE_WIDTH-1:0] mode
);

    state_t                state_r;
    logic [MODE_WIDTH-1:0] mode_r;
    logic [7:0]            led_r;
    logic [7:0]            pattern_r;
    logic [7:0]            count8_r;
    logic                  btn_prev_r;
    logic                  press_s;
    logic                  tick_s;
`ifdef LED_SEQ_BLINK_EN
    logic                  phase_r;
`endif

    assign press_s = button_center_db & ~btn_prev_r;
    assign led     = led_r;
    assign mode    = mode_r;

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES),
        .TICK_WIDTH  (TICK_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rstb  (rstb),
        .clear (press_s),
        .tick  (tick_s)
    );

    // Mode FSM plus datapath; led is loaded with the value of the state being entered or held.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r    <= ST_PASS;
            mode_r     <= ST_PASS;
            led_r      <= 8'h00;
            pattern_r  <= 8'h00;
            count8_r   <= 8'h00;
            btn_prev_r <= 1'b1;
`ifdef LED_SEQ_BLINK_EN
            phase_r    <= 1'b1;
`endif
        end else begin
            btn_prev_r <= button_center_db;
            case (state_r)
                ST_PASS: begin
                    if (press_s) begin
                        state_r   <= ST_HOLD;
                        mode_r    <= ST_HOLD;
                        pattern_r <= switch;
                    end else begin
                        state_r   <= ST_PASS;
                    end
                    led_r <= switch;
                end
                ST_HOLD: begin
                    if (press_s) begin
                        state_r <= ST_ROTATE;
                        mode_r  <= ST_ROTATE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                    led_r <= pattern_r;
                end
                ST_ROTATE: begin
                    if (press_s) begin
                        state_r  <= ST_COUNT;
                        mode_r   <= ST_COUNT;
                        count8_r <= 8'h00;
                        led_r    <= 8'h00;
                    end else if (tick_s) begin
                        pattern_r <= rotl1(pattern_r);
                        led_r     <= rotl1(pattern_r);
                    end else begin
                        led_r <= pattern_r;
                    end
                end
                ST_COUNT: begin
                    if (press_s) begin
`ifdef LED_SEQ_BLINK_EN
                        state_r <= ST_BLINK;
                        mode_r  <= ST_BLINK;
                        phase_r <= 1'b1;
                        led_r   <= pattern_r;
`else
                        state_r <= ST_PASS;
                        mode_r  <= ST_PASS;
                        led_r   <= switch;
`endif
                    end else if (tick_s) begin
                        count8_r <= count8_r + 8'h01;
                        led_r    <= count8_r + 8'h01;
                    end else begin
                        led_r <= count8_r;
                    end
                end
`ifdef LED_SEQ_BLINK_EN
                ST_BLINK: begin
                    if (press_s) begin
                        state_r <= ST_PASS;
                        mode_r  <= ST_PASS;
                        led_r   <= switch;
                    end else if (tick_s) begin
                        phase_r <= ~phase_r;
                        led_r   <= phase_r ? 8'h00 : pattern_r;
                    end else begin
                        led_r <= phase_r ? pattern_r : 8'h00;
                    end
                end
`endif
                default: begin
                    // Unreachable encodings recover to PASS
                    state_r <= ST_PASS;
                    mode_r  <= ST_PASS;
                    led_r   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed scenarios followed by
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_led_mode_sequencer;

    localparam int TC = 4;
`ifdef LED_SEQ_BLINK_EN
    localparam int NMODES = 5;
`else
    localparam int NMODES = 4;
`endif

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [7:0] switch = 8'h00;
    logic       button_center_db = 1'b0;
    logic [7:0] led;
    logic [2:0] mode;

    int errors = 0;
    int checks = 0;

    // Model: mode index, held pattern, counter, blink phase, cycles since last clear.
    int m_mode, m_pat, m_cnt, m_phase, m_age, m_prev, m_led;

    always #5 clk = ~clk;

    led_mode_sequencer #(
        .TICK_CYCLES (TC),
        .TICK_WIDTH  (32)
    ) dut (
        .clk              (clk),
        .rstb             (rstb),
        .switch           (switch),
        .button_center_db (button_center_db),
        .led              (led),
        .mode             (mode)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit press, tick;
        if (!rstb) begin
            m_mode = 0; m_pat = 0; m_cnt = 0; m_phase = 1;
            m_age = 0; m_prev = 1; m_led = 0;
        end else begin
            press = button_center_db && (m_prev == 0);
            tick  = (m_age == TC - 1);
            if (press) begin
                if (m_mode == 0) m_pat = switch;
                m_mode = (m_mode + 1) % NMODES;
                if (m_mode == 3) m_cnt = 0;
                if (m_mode == 4) m_phase = 1;
                m_age = 0;
            end else begin
                if (tick) begin
                    if (m_mode == 2) m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
                    if (m_mode == 3) m_cnt = (m_cnt + 1) % 256;
                    if (m_mode == 4) m_phase = 1 - m_phase;
                end
                m_age = (m_age + 1) % TC;
            end
            m_prev = button_center_db;
            case (m_mode)
                0:       m_led = switch;
                1, 2:    m_led = m_pat;
                3:       m_led = m_cnt;
                default: m_led = (m_phase != 0) ? m_pat : 0;
            endcase
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("model_led", led, 8'(m_led));
        check("model_mode", {5'd0, mode}, 8'(m_mode));
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Reset and PASS behaviour
        switch = 8'hA5;
        cycn(2);
        check("reset_led", led, 8'h00);
        check("reset_mode", {5'd0, mode}, 8'h00);
        rstb = 1'b1;
        #1;
        check("first_after_reset", led, 8'h00);
        cyc();
        check("pass_a5", led, 8'hA5);
        switch = 8'h3C;
        cyc();
        check("pass_3c", led, 8'h3C);

        // PASS -> HOLD captures switch
        switch = 8'h81;
        button_center_db = 1'b1;
        cyc();
        check("hold_mode", {5'd0, mode}, 8'h01);
        switch = 8'h00;
        button_center_db = 1'b0;
        cycn(3);
        check("hold_led", led, 8'h81);

        // HOLD -> ROTATE, rotate on each tick
        button_center_db = 1'b1;
        cyc();
        button_center_db = 1'b0;
        check("rot_entry", led, 8'h81);
        check("rot_mode", {5'd0, mode}, 8'h02);
        cycn(3);
        check("rot_pre_tick", led, 8'h81);
        cyc();
        check("rot_tick1", led, 8'h03);
        cycn(4);
        check("rot_tick2", led, 8'h06);

        // Press coincident with tick: advance wins, no rotation
        cycn(3);
        button_center_db = 1'b1;
        cyc();
        check("press_tick_mode", {5'd0, mode}, 8'h03);
        check("press_tick_led", led, 8'h00);

        // COUNT over wrap, with the button held for 20 cycles
        for (int n = 1; n <= 1030; n++) begin
            button_center_db = (n < 20);
            cyc();
            if (n == 25) check("held_one_advance", {5'd0, mode}, 8'h03);
            if (n == 1020) check("count_ff", led, 8'hFF);
            if (n == 1024) check("count_wrap", led, 8'h00);
            if (n == 1030) check("count_after_wrap", led, 8'h01);
        end

        button_center_db = 1'b1;
        cyc();
        button_center_db = 1'b0;
`ifdef LED_SEQ_BLINK_EN
        check("blink_mode", {5'd0, mode}, 8'h04);
        check("blink_entry", led, 8'h06);
        cycn(4);
        check("blink_off", led, 8'h00);
        cycn(4);
        check("blink_on", led, 8'h06);
        button_center_db = 1'b1;
        cyc();
        button_center_db = 1'b0;
`endif
        check("back_to_pass", {5'd0, mode}, 8'h00);
        cyc();

        // Button held across reset release produces no press
        button_center_db = 1'b1;
        rstb = 1'b0;
        cycn(2);
        rstb = 1'b1;
        cycn(3);
        check("held_through_reset", {5'd0, mode}, 8'h00);
        button_center_db = 1'b0;
        cyc();

        // Reset mid-ROTATE with prescaler at 2
        switch = 8'h5A;
        button_center_db = 1'b1; cyc();
        button_center_db = 1'b0; cyc();
        button_center_db = 1'b1; cyc();
        button_center_db = 1'b0;
        cycn(2);
        check("pre_reset_mode", {5'd0, mode}, 8'h02);
        rstb = 1'b0;
        cyc();
        check("mid_reset_led", led, 8'h00);
        check("mid_reset_mode", {5'd0, mode}, 8'h00);
        rstb = 1'b1;
        cyc();

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            switch = 8'($urandom);
            if ($urandom_range(0, 5) == 0) button_center_db = ~button_center_db;
            rstb = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 10_000_000: cycles per sequencing tick (100 ms at 100 MHz), legal range 2 to 2^TICK_WIDTH-1.
REQ-002 Parameter TICK_WIDTH, default 32: prescaler counter width.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rstb, input, 1: synchronous, active-low reset.
REQ-005 Port switch, input, 8: slide-switch value, already synchronous to clk.
REQ-006 Port button_center_db, input, 1: debounced center button level, high = pressed.
REQ-007 Port led, output, 8: registered LED drive.
REQ-008 Port mode, output, 3: registered current-mode encoding.

Function
REQ-009 A press SHALL be detected on a rising edge of button_center_db: the current sample is high and the previous registered sample is low; a press is a single-cycle internal pulse.
REQ-010 The FSM SHALL have states PASS=0, HOLD=1, ROTATE=2, COUNT=3, and BLINK=4 when BLINK is compiled in (see REQ-027).
REQ-011 Each press SHALL advance the FSM: PASS->HOLD->ROTATE->COUNT->PASS (BLINK build: COUNT->BLINK->PASS); with no press, the state SHALL hold.
REQ-012 The mode output SHALL equal the state encoding, one cycle after the press edge is sampled.
REQ-013 In PASS, led SHALL equal switch delayed by one cycle.
REQ-014 On the PASS->HOLD press, the pattern register SHALL capture switch in the same cycle; in HOLD, led = pattern.
REQ-015 The prescaler SHALL count 0..TICK_CYCLES-1 and wrap to 0; tick SHALL be asserted for exactly the one cycle where count == TICK_CYCLES-1.
REQ-016 On every press, the prescaler SHALL clear to 0, so the first tick in a new state occurs TICK_CYCLES cycles after entry.
REQ-017 In ROTATE, each tick SHALL rotate the pattern left by 1 (bit7 -> bit0); led = pattern; the rotated pattern SHALL be retained on exit.
REQ-018 On entry to COUNT, count8 SHALL load 8'h00; each tick SHALL increment it modulo 256 (8'hFF -> 8'h00); led = count8.
REQ-019 If a press and a tick occur in the same cycle, the press SHALL win: the state advances, the prescaler clears, and the tick has no effect.
REQ-020 A button held high SHALL produce exactly one press; a release SHALL produce no action.
REQ-021 Any state not listed in REQ-010 SHALL transition to PASS on the next cycle.

Reset
REQ-022 While rstb is low at a clk edge, the design SHALL set: state = PASS, mode = 3'd0, led = 8'h00, pattern = 8'h00, count8 = 8'h00, prescaler = 0, blink phase = 1.
REQ-023 The previous-button sample SHALL reset to 1, so a button held through reset deassertion produces no press.
REQ-024 Reset asserted mid-operation (any state, any prescaler value) SHALL take effect on the next clk edge with no further tick or led update.
REQ-025 In the first cycle after rstb deasserts, led SHALL show 8'h00, followed by switch values per REQ-013.

Configuration
REQ-026 Macro LED_SEQ_BLINK_EN SHALL compile the BLINK state in or out.
REQ-027 When LED_SEQ_BLINK_EN is defined:
- COUNT->BLINK->PASS;
- on entry to BLINK, phase = 1;
- each tick toggles phase;
- led = pattern when phase is 1, else 8'h00.
REQ-028 When LED_SEQ_BLINK_EN is undefined: COUNT->PASS, encoding 4 is unused (handled by REQ-021), and no phase register exists.

Structure
REQ-029 Shared package led_seq_pkg SHALL hold the state/mode encodings (PASS..BLINK) and the MODE_WIDTH=3 constant.
REQ-030 The prescaler SHALL be a sub-module tick_prescaler (params TICK_CYCLES, TICK_WIDTH; ports clk, rstb, clear, tick).
REQ-031 Press detection, FSM, and datapath registers SHALL reside in led_mode_sequencer.

Verification (TICK_CYCLES=4)
REQ-032 Reset, switch=8'hA5, no press -> mode=0; led=8'h00 one cycle after rstb rises, then 8'hA5; switch->8'h3C -> led=8'h3C one cycle later.
REQ-033 PASS with switch=8'h81, press, then switch->8'h00 -> mode=1, led held at 8'h81.
REQ-034 From HOLD 8'h81, press into ROTATE -> led 8'h81, then after 4 cycles 8'h03, after 8 cycles 8'h06; press with tick in the same cycle -> mode=3, led=8'h00, no rotation.
REQ-035 COUNT held 1030 cycles -> led steps every 4 cycles and wraps 8'hFF->8'h00 at tick 256; holding the button 20 cycles -> exactly one mode advance.
REQ-036 Button held high across rstb deassertion -> mode stays 0; rstb pulsed low mid-ROTATE at prescaler=2 -> all outputs per REQ-022 next edge.
REQ-037 BLINK build: COUNT, press -> mode=4, led=pattern; after 4 cycles led=8'h00, then pattern; next press -> mode=0. Non-BLINK build: COUNT press -> mode=0.
